// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue path: ALU function codes, RV32 opcodes and funct fields.
package alu_pkg;

   localparam logic [3:0] FN_AND = 4'b0000;
   localparam logic [3:0] FN_OR  = 4'b0001;
   localparam logic [3:0] FN_ADD = 4'b0010;
   localparam logic [3:0] FN_SUB = 4'b0110;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_AND     = 3'b111;
   localparam logic [2:0] F3_OR      = 3'b110;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [3:0] ctrl;
      logic       op2_sel_imm;
      logic       swap_ops;
      logic       illegal;
   } dec_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational RV32 decode: opcode/funct3/funct7 -> ALU function code, operand routing and an
// illegal flag for anything the ALU path does not support.
module alu_ctrl_dec
   import alu_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output logic [3:0] alu_ctrl,
   output logic       op2_sel_imm,
   output logic       swap_ops,
   output logic       illegal
);

   dec_t dec;

   // The ALU subtracts in1 from in2, so every subtraction asks the top to swap rs1/rs2.
   always_comb begin
      dec = '{ctrl: FN_ADD, op2_sel_imm: 1'b0, swap_ops: 1'b0, illegal: 1'b0};
      case (opcode)
         OPC_OP: begin
            if (funct7 != F7_BASE && funct7 != F7_ALT) begin
               dec.illegal = 1'b1;
            end else begin
               case (funct3)
                  F3_ADD_SUB: begin
                     if (funct7[5]) begin
                        dec.ctrl     = FN_SUB;
                        dec.swap_ops = 1'b1;
                     end
                  end
                  F3_AND:  dec.ctrl    = FN_AND;
                  F3_OR:   dec.ctrl    = FN_OR;
                  default: dec.illegal = 1'b1;
               endcase
            end
         end
         OPC_OP_IMM: begin
            dec.op2_sel_imm = 1'b1;
            case (funct3)
               F3_ADD_SUB: dec.ctrl    = FN_ADD;
               F3_AND:     dec.ctrl    = FN_AND;
               F3_OR:      dec.ctrl    = FN_OR;
               default:    dec.illegal = 1'b1;
            endcase
         end
         OPC_LOAD, OPC_STORE: dec.op2_sel_imm = 1'b1;
         OPC_BRANCH: begin
            dec.ctrl     = FN_SUB;
            dec.swap_ops = 1'b1;
         end
         default: dec.illegal = 1'b1;
      endcase
   end

   assign alu_ctrl    = dec.ctrl;
   assign op2_sel_imm = dec.op2_sel_imm;
   assign swap_ops    = dec.swap_ops;
   assign illegal     = dec.illegal;

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes the instruction, orders operands and registers one beat towards the ALU.
// Define ALU_ISSUE_SKID_EN for a main+skid buffer with a registered in_ready.
module alu_issue
   import alu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [XLEN-1:0]  in_rs1,
   input  logic [XLEN-1:0]  in_rs2,
   input  logic [XLEN-1:0]  in_imm,
   output logic             alu_valid,
   input  logic             alu_ready,
   output logic [XLEN-1:0]  alu_in1,
   output logic [XLEN-1:0]  alu_in2,
   output logic [3:0]       alu_ctrl,
   output logic [4:0]       alu_rd,
   output logic             illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   logic [3:0]      dec_ctrl;
   logic            op2_sel_imm;
   logic            swap_ops;
   logic            dec_illegal;
   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;
   logic            accept;
   logic            issue_new;

   // rs1/rs2 source fields are already resolved into in_rs1/in_rs2 upstream.
   logic unused_instr_bits;
   assign unused_instr_bits = ^in_instr[24:15];

   alu_ctrl_dec u_dec (
      .opcode      (in_instr[6:0]),
      .funct3      (in_instr[14:12]),
      .funct7      (in_instr[31:25]),
      .alu_ctrl    (dec_ctrl),
      .op2_sel_imm (op2_sel_imm),
      .swap_ops    (swap_ops),
      .illegal     (dec_illegal)
   );

   always_comb begin
      op1 = swap_ops ? in_rs2 : in_rs1;
      op2 = swap_ops ? in_rs1 : (op2_sel_imm ? in_imm : in_rs2);
   end

   assign accept    = in_valid & in_ready & ~flush;
   assign issue_new = accept & ~dec_illegal;

`ifdef ALU_ISSUE_SKID_EN
   logic            skid_valid;
   logic [XLEN-1:0] skid_in1;
   logic [XLEN-1:0] skid_in2;
   logic [3:0]      skid_ctrl;
   logic [4:0]      skid_rd;
   logic            main_free;

   assign main_free = ~alu_valid | alu_ready;
   assign in_ready  = ~skid_valid;

   // The skid entry is only ever filled while main is stalled, and in_ready is low while it is full,
   // so a new beat never competes with the skid entry for the main register.
   always_ff @(posedge clk) begin
      if (reset) begin
         alu_valid  <= 1'b0;
         alu_in1    <= '0;
         alu_in2    <= '0;
         alu_ctrl   <= '0;
         alu_rd     <= '0;
         skid_valid <= 1'b0;
         skid_in1   <= '0;
         skid_in2   <= '0;
         skid_ctrl  <= '0;
         skid_rd    <= '0;
      end else if (flush) begin
         alu_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (main_free) begin
         if (skid_valid) begin
            alu_valid  <= 1'b1;
            alu_in1    <= skid_in1;
            alu_in2    <= skid_in2;
            alu_ctrl   <= skid_ctrl;
            alu_rd     <= skid_rd;
            skid_valid <= 1'b0;
         end else if (issue_new) begin
            alu_valid <= 1'b1;
            alu_in1   <= op1;
            alu_in2   <= op2;
            alu_ctrl  <= dec_ctrl;
            alu_rd    <= in_instr[11:7];
         end else begin
            alu_valid <= 1'b0;
         end
      end else if (issue_new) begin
         skid_valid <= 1'b1;
         skid_in1   <= op1;
         skid_in2   <= op2;
         skid_ctrl  <= dec_ctrl;
         skid_rd    <= in_instr[11:7];
      end
   end
`else
   assign in_ready = ~alu_valid | alu_ready;

   // Data registers load only on a legal beat, which keeps them frozen through a stall.
   always_ff @(posedge clk) begin
      if (reset) begin
         alu_valid <= 1'b0;
         alu_in1   <= '0;
         alu_in2   <= '0;
         alu_ctrl  <= '0;
         alu_rd    <= '0;
      end else if (flush) begin
         alu_valid <= 1'b0;
      end else if (issue_new) begin
         alu_valid <= 1'b1;
         alu_in1   <= op1;
         alu_in2   <= op2;
         alu_ctrl  <= dec_ctrl;
         alu_rd    <= in_instr[11:7];
      end else if (alu_ready) begin
         alu_valid <= 1'b0;
      end
   end
`endif

   // Unsupported beats are consumed here and only reported; the counter sticks at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         illegal     <= 1'b0;
         illegal_cnt <= '0;
      end else begin
         illegal <= accept & dec_illegal;
         if (accept && dec_illegal && illegal_cnt != {CNT_W{1'b1}}) begin
            illegal_cnt <= illegal_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed decode table, stall/flush/reset sequences and
// randomized traffic compared against a queue-based reference model.
module tb_alu_issue;

   localparam int CNT_MAX = 255;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_rs1;
   logic [31:0] in_rs2;
   logic [31:0] in_imm;
   logic        alu_valid;
   logic        alu_ready;
   logic [31:0] alu_in1;
   logic [31:0] alu_in2;
   logic [3:0]  alu_ctrl;
   logic [4:0]  alu_rd;
   logic        illegal;
   logic [7:0]  illegal_cnt;

   int checks = 0;
   int errors = 0;

   alu_issue #(.XLEN(32), .CNT_W(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_rs1      (in_rs1),
      .in_rs2      (in_rs2),
      .in_imm      (in_imm),
      .alu_valid   (alu_valid),
      .alu_ready   (alu_ready),
      .alu_in1     (alu_in1),
      .alu_in2     (alu_in2),
      .alu_ctrl    (alu_ctrl),
      .alu_rd      (alu_rd),
      .illegal     (illegal),
      .illegal_cnt (illegal_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        legal;
      logic [3:0]  ctrl;
      logic [31:0] in1;
      logic [31:0] in2;
      logic [4:0]  rd;
   } beat_t;

   typedef enum {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_BAD} op_e;

   beat_t      q[$];
   logic       m_illegal;
   int         m_cnt;
   logic       m_zero;

   // Reference decode: pick the operation from the ISA fields, then order operands for an ALU
   // that subtracts in1 from in2.
   function automatic beat_t ref_decode(logic [31:0] instr, logic [31:0] rs1, logic [31:0] rs2,
                                        logic [31:0] imm);
      op_e         op;
      logic [31:0] a;
      logic [31:0] b;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      beat_t       r;
      op  = OP_BAD;
      a   = rs1;
      b   = rs2;
      opc = instr[6:0];
      f3  = instr[14:12];
      f7  = instr[31:25];
      if (opc == 7'h33) begin
         if (f7 == 7'h00 || f7 == 7'h20) begin
            if (f3 == 3'd0) op = (f7 == 7'h20) ? OP_SUB : OP_ADD;
            else if (f3 == 3'd7) op = OP_AND;
            else if (f3 == 3'd6) op = OP_OR;
         end
      end else if (opc == 7'h13) begin
         b = imm;
         if (f3 == 3'd0) op = OP_ADD;
         else if (f3 == 3'd7) op = OP_AND;
         else if (f3 == 3'd6) op = OP_OR;
      end else if (opc == 7'h03 || opc == 7'h23) begin
         op = OP_ADD;
         b  = imm;
      end else if (opc == 7'h63) begin
         op = OP_SUB;
      end
      r.legal = (op != OP_BAD);
      r.rd    = instr[11:7];
      r.in1   = a;
      r.in2   = b;
      case (op)
         OP_SUB: begin
            r.ctrl = 4'b0110;
            r.in1  = b;
            r.in2  = a;
         end
         OP_AND:  r.ctrl = 4'b0000;
         OP_OR:   r.ctrl = 4'b0001;
         default: r.ctrl = 4'b0010;
      endcase
      return r;
   endfunction

   function automatic logic model_ready();
`ifdef ALU_ISSUE_SKID_EN
      return q.size() < 2;
`else
      return (q.size() == 0) || alu_ready;
`endif
   endfunction

   task automatic model_update();
      beat_t b;
      logic  acc;
      if (reset) begin
         q.delete();
         m_illegal = 1'b0;
         m_cnt     = 0;
         m_zero    = 1'b1;
      end else if (flush) begin
         q.delete();
         m_illegal = 1'b0;
      end else begin
         acc = in_valid && model_ready();
         b   = ref_decode(in_instr, in_rs1, in_rs2, in_imm);
         if (q.size() > 0 && alu_ready) void'(q.pop_front());
         if (acc && b.legal) begin
            q.push_back(b);
            m_zero = 1'b0;
         end
         m_illegal = acc && !b.legal;
         if (acc && !b.legal && m_cnt < CNT_MAX) m_cnt++;
      end
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput();
      chk("alu_valid", {31'b0, alu_valid}, {31'b0, q.size() > 0});
      chk("illegal", {31'b0, illegal}, {31'b0, m_illegal});
      chk("illegal_cnt", {24'b0, illegal_cnt}, m_cnt);
      if (q.size() > 0) begin
         chk("alu_ctrl", {28'b0, alu_ctrl}, {28'b0, q[0].ctrl});
         chk("alu_in1", alu_in1, q[0].in1);
         chk("alu_in2", alu_in2, q[0].in2);
         chk("alu_rd", {27'b0, alu_rd}, {27'b0, q[0].rd});
      end else if (m_zero) begin
         chk("zero_ctrl", {28'b0, alu_ctrl}, 32'd0);
         chk("zero_in1", alu_in1, 32'd0);
         chk("zero_in2", alu_in2, 32'd0);
         chk("zero_rd", {27'b0, alu_rd}, 32'd0);
      end
   endtask

   task automatic applyStimulus(logic v, logic [31:0] instr, logic [31:0] rs1, logic [31:0] rs2,
                                logic [31:0] imm, logic rdy, logic fl);
      in_valid  = v;
      in_instr  = instr;
      in_rs1    = rs1;
      in_rs2    = rs2;
      in_imm    = imm;
      alu_ready = rdy;
      flush     = fl;
   endtask

   // One clock: check the handshake before the edge, advance the model, check outputs after.
   task automatic step();
      #1;
      chk("in_ready", {31'b0, in_ready}, {31'b0, model_ready()});
      @(posedge clk);
      model_update();
      #1;
      checkOutput();
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0] opc;
      logic [6:0] f7;
      int unsigned k;
      k = $urandom_range(0, 9);
      case (k)
         0, 1, 2: opc = 7'h33;
         3, 4:    opc = 7'h13;
         5:       opc = 7'h03;
         6:       opc = 7'h23;
         7:       opc = 7'h63;
         8:       opc = 7'h37;
         default: opc = 7'($urandom);
      endcase
      k = $urandom_range(0, 4);
      f7 = (k < 2) ? 7'h00 : ((k < 4) ? 7'h20 : 7'($urandom));
      return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
   endfunction

   typedef struct {
      logic [31:0] instr;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] imm;
      logic        legal;
      logic [3:0]  ctrl;
      logic [31:0] in1;
      logic [31:0] in2;
   } vec_t;

   localparam logic [31:0] LUI_X7 = {20'h12345, 5'd7, 7'h37};
   localparam logic [31:0] ADD_X3 = 32'h002081B3;
   localparam logic [31:0] SUB_X3 = 32'h402081B3;

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      vec_t vecs[14];
      int   cnt_before;

      vecs[0]  = '{ADD_X3, 32'd5, 32'd7, 32'd0, 1'b1, 4'b0010, 32'd5, 32'd7};
      vecs[1]  = '{SUB_X3, 32'd10, 32'd3, 32'd0, 1'b1, 4'b0110, 32'd3, 32'd10};
      vecs[2]  = '{{12'h0F0, 5'd1, 3'b110, 5'd5, 7'h13}, 32'h0F, 32'h55, 32'hF0,
                   1'b1, 4'b0001, 32'h0F, 32'hF0};
      vecs[3]  = '{{12'h0FF, 5'd1, 3'b111, 5'd6, 7'h13}, 32'h0F, 32'h55, 32'hFF,
                   1'b1, 4'b0000, 32'h0F, 32'hFF};
      vecs[4]  = '{LUI_X7, 32'd1, 32'd2, 32'd3, 1'b0, 4'b0000, 32'd0, 32'd0};
      vecs[5]  = '{{12'h004, 5'd2, 3'b010, 5'd8, 7'h03}, 32'h100, 32'h9, 32'h4,
                   1'b1, 4'b0010, 32'h100, 32'h4};
      vecs[6]  = '{{7'h7F, 5'd3, 5'd2, 3'b010, 5'h18, 7'h23}, 32'h200, 32'h9, 32'hFFFF_FFF8,
                   1'b1, 4'b0010, 32'h200, 32'hFFFF_FFF8};
      vecs[7]  = '{{7'h00, 5'd3, 5'd2, 3'b000, 5'd4, 7'h63}, 32'd20, 32'd9, 32'h10,
                   1'b1, 4'b0110, 32'd9, 32'd20};
      vecs[8]  = '{{7'h00, 5'd2, 5'd1, 3'b111, 5'd4, 7'h33}, 32'hF0F0, 32'hFF00, 32'h0,
                   1'b1, 4'b0000, 32'hF0F0, 32'hFF00};
      vecs[9]  = '{{7'h00, 5'd2, 5'd1, 3'b110, 5'd9, 7'h33}, 32'hF0F0, 32'hFF00, 32'h0,
                   1'b1, 4'b0001, 32'hF0F0, 32'hFF00};
      vecs[10] = '{{7'h01, 5'd2, 5'd1, 3'b000, 5'd9, 7'h33}, 32'd6, 32'd7, 32'h0,
                   1'b0, 4'b0000, 32'd0, 32'd0};
      vecs[11] = '{{12'h003, 5'd1, 3'b001, 5'd9, 7'h13}, 32'd6, 32'd7, 32'h3,
                   1'b0, 4'b0000, 32'd0, 32'd0};
      vecs[12] = '{{7'h00, 5'd2, 5'd1, 3'b100, 5'd9, 7'h33}, 32'd6, 32'd7, 32'h0,
                   1'b0, 4'b0000, 32'd0, 32'd0};
      vecs[13] = '{{12'hFFF, 5'd1, 3'b000, 5'd31, 7'h13}, 32'd100, 32'd7, 32'hFFFF_FFFF,
                   1'b1, 4'b0010, 32'd100, 32'hFFFF_FFFF};

      // Power-on reset without handshake checks, since outputs are unknown until it takes effect.
      reset = 1'b1;
      applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      repeat (3) @(posedge clk);
      model_update();
      #1;
      reset = 1'b0;
      checkOutput();
      chk("reset_in_ready", {31'b0, in_ready}, 32'd1);

      $display("[TB] directed decode table");
      for (int i = 0; i < 14; i++) begin
         applyStimulus(1'b1, vecs[i].instr, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, 1'b1, 1'b0);
         step();
         chk($sformatf("vec%0d_valid", i), {31'b0, alu_valid}, {31'b0, vecs[i].legal});
         chk($sformatf("vec%0d_illegal", i), {31'b0, illegal}, {31'b0, !vecs[i].legal});
         if (vecs[i].legal) begin
            chk($sformatf("vec%0d_ctrl", i), {28'b0, alu_ctrl}, {28'b0, vecs[i].ctrl});
            chk($sformatf("vec%0d_in1", i), alu_in1, vecs[i].in1);
            chk($sformatf("vec%0d_in2", i), alu_in2, vecs[i].in2);
            chk($sformatf("vec%0d_rd", i), {27'b0, alu_rd}, {27'b0, vecs[i].instr[11:7]});
         end
      end
      applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      step();

      $display("[TB] stall with input held");
      applyStimulus(1'b1, ADD_X3, 32'd5, 32'd7, 32'd0, 1'b1, 1'b0);
      step();
      applyStimulus(1'b1, SUB_X3, 32'd10, 32'd3, 32'd0, 1'b0, 1'b0);
      repeat (3) step();
      chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
      chk("stall_in1", alu_in1, 32'd5);
      alu_ready = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (3) step();

      $display("[TB] flush over a held beat");
      applyStimulus(1'b1, ADD_X3, 32'd1, 32'd2, 32'd0, 1'b1, 1'b0);
      step();
      cnt_before = m_cnt;
      applyStimulus(1'b1, LUI_X7, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      step();
      chk("flush_valid", {31'b0, alu_valid}, 32'd0);
      chk("flush_cnt", {24'b0, illegal_cnt}, cnt_before);
      applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      step();

      $display("[TB] saturating illegal counter");
      applyStimulus(1'b1, LUI_X7, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      repeat (300) step();
      chk("cnt_saturated", {24'b0, illegal_cnt}, 32'd255);
      in_valid = 1'b0;
      step();

      $display("[TB] reset mid-stall, together with flush");
      applyStimulus(1'b1, SUB_X3, 32'd9, 32'd4, 32'd0, 1'b1, 1'b0);
      step();
      applyStimulus(1'b1, ADD_X3, 32'd3, 32'd3, 32'd0, 1'b0, 1'b1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst_valid", {31'b0, alu_valid}, 32'd0);
      chk("rst_in2", alu_in2, 32'd0);
      chk("rst_cnt", {24'b0, illegal_cnt}, 32'd0);
      applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      step();

      $display("[TB] randomized traffic");
      for (int n = 0; n < 3000; n++) begin
         applyStimulus(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom, $urandom,
                       1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0));
         reset = ($urandom_range(0, 299) == 0);
         step();
      end
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
